// File: rtl/sprite_motion_ctrl_pkg.sv
// sprite_motion_ctrl_pkg: state encoding, screen geometry and the per-axis move/clamp helper.
package sprite_motion_ctrl_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN = 2'd1;
  localparam state_t ST_BLINK = 2'd2;
  localparam int SCREEN_X = 640;
  localparam int SCREEN_Y = 480;
  // Returns {hit, new_pos}; 11-bit signed so both underflow and overflow show up.
  function automatic logic [10:0] clamp_axis(input logic [9:0] pos, input logic inc, input logic dec,
                                             input logic [9:0] step, input logic [9:0] lim);
    logic signed [10:0] d, n;
    d = (inc && !dec) ? $signed({1'b0, step}) : (dec && !inc) ? -$signed({1'b0, step}) : 11'sd0;
    n = $signed({1'b0, pos}) + d;
    return n < 11'sd0 ? {1'b1, 10'd0} : n > $signed({1'b0, lim}) ? {1'b1, lim} : {1'b0, n[9:0]};
  endfunction
endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// sprite_motion_ctrl_if: VGA counters and buttons in, renderer controls out.
interface sprite_motion_ctrl_if;
  logic [9:0] column_count;
  logic [9:0] row_count;
  logic start;
  logic up;
  logic down;
  logic left;
  logic right;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic enable;
  logic [2:0] color_sprite;
  logic frame_tick;
  modport master (
    input column_count, row_count, start, up, down, left, right,
    output pos_x, pos_y, enable, color_sprite, frame_tick
  );
  modport slave (
    output column_count, row_count, start, up, down, left, right,
    input pos_x, pos_y, enable, color_sprite, frame_tick
  );
endinterface

// File: rtl/sprite_motion_ctrl_frame_tick_gen.sv
// sprite_motion_ctrl_frame_tick_gen: one-cycle pulse at the start of vertical blanking.
module sprite_motion_ctrl_frame_tick_gen
  import sprite_motion_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] column_count,
  input  logic [9:0] row_count,
  output logic       tick
);
  logic cond, cond_q;
  assign cond = row_count == 10'(SCREEN_Y) && column_count == 10'd0;
  // Edge-detected so counters held for several clocks still give one pulse.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {cond_q, tick} <= 2'b00;
    else {cond_q, tick} <= {cond, cond & ~cond_q};
endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame sprite position/enable/colour scheduler with wall-hit blink.
module sprite_motion_ctrl
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int SIZE_X = 32,
  parameter int SIZE_Y = 32,
  parameter int STEP = 4,
  parameter int INIT_X = 304,
  parameter int INIT_Y = 224,
  parameter int BLINK_FRAMES = 8,
  parameter logic [2:0] SPRITE_COLOR = 3'b010,
  parameter logic [2:0] HIT_COLOR = 3'b100
) (
  input logic clk,
  input logic rst_n,
  sprite_motion_ctrl_if.master bus
);
  localparam int CW = $clog2(BLINK_FRAMES);
  localparam logic [9:0] MAX_X = 10'(SCREEN_X - SIZE_X - 1);
  localparam logic [9:0] MAX_Y = 10'(SCREEN_Y - SIZE_Y - 1);
  state_t state_q, state_d;
  logic [9:0] px_q, px_d, py_q, py_d, mx, my;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] s1, s2;
  logic tick, hx, hy, start_s, up_s, down_s, left_s, right_s;
  sprite_motion_ctrl_frame_tick_gen u_tick (
    .clk(clk), .rst_n(rst_n), .column_count(bus.column_count), .row_count(bus.row_count), .tick(tick)
  );
  assign {start_s, up_s, down_s, left_s, right_s} = s2;
  assign {hx, mx} = clamp_axis(px_q, right_s, left_s, 10'(STEP), MAX_X);
  assign {hy, my} = clamp_axis(py_q, down_s, up_s, 10'(STEP), MAX_Y);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      state_q <= ST_IDLE;
      px_q <= 10'(INIT_X);
      py_q <= 10'(INIT_Y);
      cnt_q <= '0;
    end else begin
      s1 <= {bus.start, bus.up, bus.down, bus.left, bus.right};
      s2 <= s1;
      state_q <= state_d;
      px_q <= px_d;
      py_q <= py_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = (state_q == 2'd3) ? ST_IDLE : state_q;
    px_d = px_q;
    py_d = py_q;
    cnt_d = cnt_q;
    if (tick && state_q == ST_IDLE && start_s) begin
      state_d = ST_RUN;
      px_d = 10'(INIT_X);
      py_d = 10'(INIT_Y);
    end
    if (tick && state_q == ST_RUN) begin
      px_d = mx;
      py_d = my;
      if (hx || hy) begin
        state_d = ST_BLINK;
        cnt_d = '0;
      end
    end
    if (tick && state_q == ST_BLINK) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(BLINK_FRAMES - 1)) state_d = ST_RUN;
    end
  end
  always_comb begin
    bus.pos_x = px_q;
    bus.pos_y = py_q;
    bus.enable = state_q == ST_RUN || (state_q == ST_BLINK && !cnt_q[1]);
    bus.color_sprite = state_q == ST_BLINK ? HIT_COLOR : SPRITE_COLOR;
    bus.frame_tick = tick;
  end
endmodule
